// File: rtl/axi_ram.sv
// axi_ram: AXI4-Lite responder backed by a word-organised synchronous RAM
module axi_ram #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int                    IW     = $clog2(DEPTH);
    localparam int                    NB     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(DEPTH * 4);
    localparam logic [0:0]            W_IDLE = 1'b0;
    localparam logic [0:0]            W_RESP = 1'b1;
    localparam logic [0:0]            R_IDLE = 1'b0;
    localparam logic [0:0]            R_DATA = 1'b1;
    localparam logic [1:0]            OKAY   = 2'b00;
    localparam logic [1:0]            SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            wstate_q, wstate_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  aw_hs, w_hs, commit, wr_in;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_off;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_strb;
    logic [IW-1:0]         wr_idx;

    logic [0:0]            rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ar_hs, rd_in;
    logic [ADDR_WIDTH-1:0] rd_off;
    logic [IW-1:0]         rd_idx;

    logic unused;
    assign unused = ^{awprot, arprot, wr_off, rd_off};

    // Write path: hold AW and W independently, commit once both are present
    always_comb begin
        aw_hs     = awvalid & awready_q;
        w_hs      = wvalid & wready_q;
        wr_addr   = aw_held_q ? awaddr_q : awaddr;
        wr_data   = w_held_q ? wdata_q : wdata;
        wr_strb   = w_held_q ? wstrb_q : wstrb;
        wr_off    = wr_addr - BASE_ADDR;
        wr_in     = wr_off < SPAN;
        wr_idx    = wr_off[IW+1:2];
        commit    = (wstate_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
        wstate_d  = wstate_q;
        bresp_d   = bresp_q;
        aw_held_d = aw_held_q | aw_hs;
        w_held_d  = w_held_q | w_hs;
        awaddr_d  = aw_hs ? awaddr : awaddr_q;
        wdata_d   = w_hs ? wdata : wdata_q;
        wstrb_d   = w_hs ? wstrb : wstrb_q;
        if (commit) begin
            wstate_d = W_RESP;
            bresp_d  = wr_in ? OKAY : SLVERR;
        end else if (wstate_q == W_RESP && bready) begin
            wstate_d  = W_IDLE;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        awready_d = ~aw_held_d & (wstate_d == W_IDLE);
        wready_d  = ~w_held_d & (wstate_d == W_IDLE);
    end

    // Write path state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    // RAM byte-lane write on commit; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_in)
            for (int i = 0; i < NB; i++)
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end

    // Read path next state: one outstanding read, response one cycle after AR
    always_comb begin
        ar_hs     = arvalid & arready_q;
        rd_off    = araddr - BASE_ADDR;
        rd_in     = rd_off < SPAN;
        rd_idx    = rd_off[IW+1:2];
        rstate_d  = ar_hs ? R_DATA : (rstate_q == R_DATA && rready) ? R_IDLE : rstate_q;
        rresp_d   = ar_hs ? (rd_in ? OKAY : SLVERR) : rresp_q;
        arready_d = rstate_d == R_IDLE;
    end

    // Read path registers; the RAM read here sees pre-write contents
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rresp_q   <= rresp_d;
            if (ar_hs) rdata_q <= rd_in ? mem[rd_idx] : '0;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = wstate_q == W_RESP;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rstate_q == R_DATA;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
endmodule

// File: tb/tb_axi_ram.sv
// tb_axi_ram: vector table, hand sequences and randomized checks for axi_ram
module tb_axi_ram;
    localparam int          DEPTH = 256;
    localparam logic [31:0] B     = 32'h0001_0000;
    localparam logic [31:0] S     = DEPTH * 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;

    int checks = 0, errors = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    axi_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(B)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(3'b000), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(3'b000), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        logic [31:0] wa, wd;
        logic [3:0]  ws;
        int          ad, wdl, hold;
        logic [31:0] ra;
        logic [1:0]  eb;
        logic [31:0] er;
        logic [1:0]  err;
    } vec_t;
    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a - B) < S;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_rng(a))
            for (int i = 0; i < 4; i++)
                if (s[i]) model[int'((a - B) >> 2)][8*i +: 8] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return in_rng(a) ? model[int'((a - B) >> 2)] : 32'h0;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int ad, input int wdl, input int hold,
                            output logic [1:0] resp, output int lat, output int viol);
        bit awd, wdn;
        awd = 0; wdn = 0; viol = 0; lat = 0;
        awaddr = a; wdata = d; wstrb = s;
        for (int c = 0; c < 40 && !(awd && wdn); c++) begin
            @(negedge clk);
            awvalid = !awd && c >= ad;
            wvalid  = !wdn && c >= wdl;
            #1;
            if (awd && awready) viol++;
            if (wdn && wready) viol++;
            if (bvalid) viol++;
            if (awvalid && awready) awd = 1;
            if (wvalid && wready) wdn = 1;
        end
        do begin
            @(negedge clk);
            awvalid = 0; wvalid = 0; lat++;
            #1;
        end while (!bvalid && lat < 20);
        resp = bresp;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            if (!bvalid || bresp !== resp || awready || wready) viol++;
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        #1;
        if (!awready || !wready || bvalid) viol++;
    endtask

    task automatic do_read(input logic [31:0] a, input int hold,
                           output logic [31:0] d, output logic [1:0] resp, output int lat, output int viol);
        int c;
        c = 0; viol = 0; lat = 0;
        araddr = a;
        @(negedge clk);
        arvalid = 1;
        #1;
        while (!arready && c < 40) begin
            @(negedge clk); #1; c++;
        end
        do begin
            @(negedge clk);
            arvalid = 0; lat++;
            #1;
        end while (!rvalid && lat < 20);
        d = rdata; resp = rresp;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            if (!rvalid || rdata !== d || rresp !== resp || arready) viol++;
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        #1;
        if (!arready || rvalid) viol++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd, a, ra, d;
        logic [3:0]  s;
        int          bl, bv, rl, rv;

        vt[0]  = '{B + 32'h10,    32'hDEADBEEF, 4'hF, 0, 0, 0, B + 32'h10,    2'b00, 32'hDEADBEEF, 2'b00};
        vt[1]  = '{B + 32'h20,    32'h11223344, 4'hF, 3, 0, 0, B + 32'h20,    2'b00, 32'h11223344, 2'b00};
        vt[2]  = '{B + 32'h20,    32'hAABBCCDD, 4'h5, 0, 3, 5, B + 32'h20,    2'b00, 32'h11BB33DD, 2'b00};
        vt[3]  = '{B,             32'hCAFEF00D, 4'hF, 0, 0, 0, B,             2'b00, 32'hCAFEF00D, 2'b00};
        vt[4]  = '{B + S,         32'h12345678, 4'hF, 0, 0, 0, B,             2'b10, 32'hCAFEF00D, 2'b00};
        vt[5]  = '{B + 32'h30,    32'h00000001, 4'hF, 1, 1, 0, B + S,         2'b00, 32'h00000000, 2'b10};
        vt[6]  = '{B + 32'h27,    32'h0BADF00D, 4'hF, 0, 2, 0, B + 32'h24,    2'b00, 32'h0BADF00D, 2'b00};
        vt[7]  = '{B + 32'h10,    32'hFFFFFFFF, 4'h0, 0, 0, 0, B + 32'h10,    2'b00, 32'hDEADBEEF, 2'b00};
        vt[8]  = '{B + 32'h10,    32'h12345678, 4'hA, 2, 1, 3, B + 32'h10,    2'b00, 32'h12AD56EF, 2'b00};
        vt[9]  = '{B - 32'h4,     32'h5A5A5A5A, 4'hF, 0, 0, 0, B - 32'h4,     2'b10, 32'h00000000, 2'b10};
        vt[10] = '{B + S - 32'h4, 32'h600DCAFE, 4'hF, 0, 0, 0, B + S - 32'h4, 2'b00, 32'h600DCAFE, 2'b00};

        repeat (3) @(negedge clk);
        #1;
        chk("reset awready", 32'(awready), 0);
        chk("reset wready", 32'(wready), 0);
        chk("reset arready", 32'(arready), 0);
        chk("reset bvalid", 32'(bvalid), 0);
        chk("reset rvalid", 32'(rvalid), 0);
        chk("reset bresp", 32'(bresp), 0);
        chk("reset rresp", 32'(rresp), 0);
        chk("reset rdata", rdata, 0);
        rst = 0;
        @(negedge clk); #1;
        chk("post-reset readies", {29'h0, awready, wready, arready}, 32'h7);

        foreach (vt[i]) begin
            do_write(vt[i].wa, vt[i].wd, vt[i].ws, vt[i].ad, vt[i].wdl, vt[i].hold, br, bl, bv);
            model_write(vt[i].wa, vt[i].wd, vt[i].ws);
            chk($sformatf("vec%0d bresp", i), 32'(br), 32'(vt[i].eb));
            chk($sformatf("vec%0d b latency", i), bl, 1);
            chk($sformatf("vec%0d write handshake violations", i), bv, 0);
            do_read(vt[i].ra, vt[i].hold, rd, rr, rl, rv);
            chk($sformatf("vec%0d rdata", i), rd, vt[i].er);
            chk($sformatf("vec%0d rresp", i), 32'(rr), 32'(vt[i].err));
            chk($sformatf("vec%0d r latency", i), rl, 1);
            chk($sformatf("vec%0d read handshake violations", i), rv, 0);
        end

        do_write(B + 32'h40, 32'hAAAA0000, 4'hF, 0, 0, 0, br, bl, bv);
        model_write(B + 32'h40, 32'hAAAA0000, 4'hF);
        fork
            do_write(B + 32'h40, 32'h00000055, 4'hF, 0, 0, 0, br, bl, bv);
            do_read(B + 32'h40, 0, rd, rr, rl, rv);
        join
        chk("collision read old value", rd, 32'hAAAA0000);
        chk("collision bresp", 32'(br), 0);
        model_write(B + 32'h40, 32'h00000055, 4'hF);
        do_read(B + 32'h40, 0, rd, rr, rl, rv);
        chk("collision later read new value", rd, 32'h00000055);

        do_write(B + 32'h58, 32'h13572468, 4'hF, 0, 0, 0, br, bl, bv);
        model_write(B + 32'h58, 32'h13572468, 4'hF);
        @(negedge clk);
        awaddr = B + 32'h50; wdata = 32'h77777777; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        #1;
        chk("bvalid before reset", 32'(bvalid), 1);
        model_write(B + 32'h50, 32'h77777777, 4'hF);
        @(negedge clk);
        rst = 1;
        @(negedge clk); #1;
        chk("reset drops bvalid", 32'(bvalid), 0);
        chk("readies low in reset", {29'h0, awready, wready, arready}, 0);
        rst = 0;
        @(negedge clk); #1;
        chk("readies high after reset", {29'h0, awready, wready, arready}, 32'h7);
        awaddr = B + 32'h58; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        do_write(B + 32'h5C, 32'h0F0F0F0F, 4'hF, 0, 0, 0, br, bl, bv);
        model_write(B + 32'h5C, 32'h0F0F0F0F, 4'hF);
        chk("post-reset write bresp", 32'(br), 0);
        do_read(B + 32'h58, 0, rd, rr, rl, rv);
        chk("partial write dropped by reset", rd, model_read(B + 32'h58));
        do_read(B + 32'h5C, 0, rd, rr, rl, rv);
        chk("post-reset write landed", rd, 32'h0F0F0F0F);
        do_read(B + 32'h50, 0, rd, rr, rl, rv);
        chk("committed write before reset", rd, 32'h77777777);

        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            do_write(B + 32'h100 + 32'(4 * k), d, 4'hF, 0, 0, 0, br, bl, bv);
            model_write(B + 32'h100 + 32'(4 * k), d, 4'hF);
            chk("pool preload bresp", 32'(br), 0);
        end
        for (int it = 0; it < 60; it++) begin
            a  = ($urandom_range(0, 7) == 0) ? B + S + 32'(4 * $urandom_range(0, 15))
                                             : B + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? B - 32'(4 * $urandom_range(1, 16))
                                             : B + 32'h100 + 32'(4 * $urandom_range(0, 15));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), br, bl, bv);
            chk("rand bresp", 32'(br), in_rng(a) ? 32'h0 : 32'h2);
            chk("rand b latency", bl, 1);
            chk("rand write violations", bv, 0);
            model_write(a, d, s);
            do_read(ra, $urandom_range(0, 2), rd, rr, rl, rv);
            chk("rand rdata", rd, model_read(ra));
            chk("rand rresp", 32'(rr), in_rng(ra) ? 32'h0 : 32'h2);
            chk("rand read violations", rv, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_ram.md
Name: axi_ram

Overview:
AXI4-Lite responder backed by a word-organised synchronous RAM. It is the slave end of the CPU's code/data/mmio master ports and is used as instruction or data memory in SoC tops and benches. Read and write channels are independent, with one outstanding transaction per direction. Out-of-range accesses return SLVERR.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr
DATA_WIDTH, 32, data bus width; only 32 supported (4 byte lanes)
DEPTH, 1024, number of words of storage; power of two
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; aligned to DEPTH*4

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
awaddr  in  ADDR_WIDTH  write address
awprot  in  3  ignored
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte lane enables
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response (00 OKAY, 10 SLVERR)
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arprot  in  3  ignored
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read response valid
rready  in  1  read response ready

Behaviour:
- Reset (rst=1 at a clk edge): awready, wready, arready, bvalid and rvalid are 0; bresp and rresp are 00; rdata is 0. All held AW/W/AR state is cleared. RAM contents are not reset. Readies go to 1 on the first cycle after rst deasserts.
- Reset mid-transaction drops the transaction. A pending bvalid or rvalid falls to 0 at the next edge, and no RAM write occurs for a partially captured write.
- Address decode: offset = addr - BASE_ADDR. The access is in range iff offset < DEPTH*4. Word index = offset[log2(DEPTH)+1:2]. Bits [1:0] are ignored, so unaligned addresses are treated as aligned.
- Write path has states W_IDLE and W_RESP; AW and W are captured independently.
  - awready = ~aw_held & ~bvalid, registered. wready = ~w_held & ~bvalid, registered.
  - AW and W may arrive in either order, or in the same cycle.
  - On the edge where both AW and W are held, the RAM is written for lanes with wstrb[i]=1, only if in range. The state moves to W_RESP with bvalid=1 and bresp=00 if in range, else 10.
  - Minimum latency: bvalid is asserted 1 cycle after the AW+W handshake cycle.
  - W_RESP holds bvalid and bresp stable until bvalid&bready. Then it clears the held flags, returns to W_IDLE, and awready/wready are 1 in the next cycle.
  - wstrb=0 performs no write and still returns OKAY.
- Read path has states R_IDLE, R_DATA.
  - arready=1 only in R_IDLE.
  - An AR handshake triggers a synchronous RAM read. The next cycle enters R_DATA with rvalid=1, rdata = word (0 if out of range) and rresp = 00 or 10.
  - rdata and rresp are held stable while rvalid & ~rready.
  - On rvalid&rready, return to R_IDLE; arready=1 the next cycle.
  - Throughput is 1 read per 2 cycles.
- Same-cycle read and write commit to the same word: the read returns the old contents (read-before-write). A later read returns the new data.
- Write and read channels never block each other.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 with wstrb=1111, AW and W in the same cycle -> bvalid one cycle later with bresp=00. Reading 0x10 then returns rdata=0xDEADBEEF, rresp=00, with rvalid one cycle after the AR handshake.
- Write with W three cycles before AW, then AW three cycles before W -> both complete. wready/awready drop after their own handshake and bvalid appears only after both are captured.
- Byte strobes: preload 0x11223344, write 0xAABBCCDD with wstrb=0101 -> read returns 0x11BB33DD.
- Out of range at address BASE_ADDR+DEPTH*4 -> bresp=10 with the RAM unchanged (word 0 still reads its prior value); read returns rresp=10, rdata=0.
- Backpressure: hold bready=0 and rready=0 for 5 cycles -> bvalid, rvalid, rdata and resp stay stable, and awready/wready/arready stay 0 until the response handshakes.
- Collision and reset: write 0x55 and read the same address in the commit cycle -> read returns the old value. Asserting rst while bvalid=1 -> bvalid=0 and all readies 0 next cycle, readies 1 after release.
